// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared encodings and constants for the audio play scheduler
package audio_pkg;

    localparam int NUM_CLIPS            = 8;
    localparam int SEL_W                = 3;
    localparam int DEFAULT_CLK_FREQ     = 100_000_000;
    localparam int DEFAULT_AUDIO_PERIOD = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_SETUP = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - combinational round-robin grant over an 8-bit pending mask
module rr_arbiter8
    import audio_pkg::*;
(
    input  logic [NUM_CLIPS-1:0] pending,
    input  logic [SEL_W-1:0]     last,
    output logic                 grant_valid,
    output logic [SEL_W-1:0]     grant_idx
);

    logic [SEL_W-1:0] cand;

    // Search starts just after the previous winner; i=8 wraps back onto last itself.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last;
        cand        = last;
        for (int i = 1; i <= NUM_CLIPS; i++) begin
            cand = last + i[SEL_W-1:0];
            if (!grant_valid && pending[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/audio_play_scheduler.sv
// rtl/audio_play_scheduler.sv - arbitrates clip requests and sequences the I2S transmitter enable/select
module audio_play_scheduler
    import audio_pkg::*;
#(
    parameter int                   CLK_FREQ     = DEFAULT_CLK_FREQ,
    parameter int                   AUDIO_PERIOD = DEFAULT_AUDIO_PERIOD,
    parameter int                   CLIP_CYCLES  = CLK_FREQ * AUDIO_PERIOD,
    parameter int                   SETUP_CYCLES = 16,
    parameter int                   GAP_CYCLES   = CLK_FREQ / 100,
    parameter logic [NUM_CLIPS-1:0] CLIP_MASK    = 8'h01
) (
    input  logic                 MCLK,
    input  logic                 rst_n,
    input  logic [NUM_CLIPS-1:0] req,
    input  logic                 stop,
    input  logic                 loop_en,
    output logic                 tx_enable,
    output logic [SEL_W-1:0]     tx_sel,
    output logic                 busy,
    output logic [NUM_CLIPS-1:0] pending,
    output logic                 done,
    output logic                 dropped
);

    localparam int CNT_MAX = max3(CLIP_CYCLES, GAP_CYCLES, SETUP_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLIP_LOAD  = CNT_W'(CLIP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [NUM_CLIPS-1:0] req_q;
    logic [NUM_CLIPS-1:0] rise;
    logic [NUM_CLIPS-1:0] grant_clear;
    logic [SEL_W-1:0]     last;
    logic                 grant_valid;
    logic [SEL_W-1:0]     grant_idx;
    logic                 grant_take;

    rr_arbiter8 u_arb (
        .pending     (pending),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign rise        = req & ~req_q;
    assign grant_take  = (state == ST_ARB) && grant_valid && !stop;
    assign grant_clear = grant_take ? (NUM_CLIPS'(1) << grant_idx) : '0;

    always_ff @(posedge MCLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            req_q   <= '0;
            pending <= '0;
            dropped <= 1'b0;
            tx_sel  <= '0;
            last    <= SEL_W'(NUM_CLIPS - 1);
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            req_q   <= req;
            pending <= stop ? '0 : ((pending | (rise & CLIP_MASK)) & ~grant_clear);
            dropped <= !stop && (|(rise & (~CLIP_MASK | pending)));
            if (grant_take) begin
                tx_sel <= grant_idx;
                last   <= grant_idx;
            end
        end
    end

    // Each state entry reloads the shared down-counter; a state exits when it reaches zero.
    always_comb begin
        state_next = state;
        cnt_next   = (cnt != '0) ? (cnt - CNT_W'(1)) : cnt;
        if (stop) begin
            if (state != ST_IDLE) begin
                state_next = ST_GAP;
                cnt_next   = GAP_LOAD;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pending != '0) state_next = ST_ARB;
                end
                ST_ARB: begin
                    if (grant_valid) begin
                        state_next = ST_SETUP;
                        cnt_next   = SETUP_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        state_next = ST_PLAY;
                        cnt_next   = CLIP_LOAD;
                    end
                end
                ST_PLAY: begin
                    if (cnt == '0) begin
                        state_next = ST_GAP;
                        cnt_next   = GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        if (pending != '0) begin
                            state_next = ST_ARB;
                        end else if (loop_en) begin
                            state_next = ST_SETUP;
                            cnt_next   = SETUP_LOAD;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        tx_enable = (state == ST_PLAY);
        busy      = (state != ST_IDLE);
        done      = (state == ST_PLAY) && (cnt == '0) && !stop;
    end

endmodule

// File: tb/tb_audio_play_scheduler.sv
// tb/tb_audio_play_scheduler.sv - directed self-checking bench for audio_play_scheduler
module tb_audio_play_scheduler;

    logic       MCLK;
    logic       rst_n;
    logic [7:0] req;
    logic       stop;
    logic       loop_en;
    logic       tx_enable;
    logic [2:0] tx_sel;
    logic       busy;
    logic [7:0] pending;
    logic       done;
    logic       dropped;

    int n_checks = 0;
    int n_fail   = 0;

    audio_play_scheduler #(
        .CLIP_CYCLES  (20),
        .SETUP_CYCLES (2),
        .GAP_CYCLES   (4),
        .CLIP_MASK    (8'h0F)
    ) dut (
        .MCLK      (MCLK),
        .rst_n     (rst_n),
        .req       (req),
        .stop      (stop),
        .loop_en   (loop_en),
        .tx_enable (tx_enable),
        .tx_sel    (tx_sel),
        .busy      (busy),
        .pending   (pending),
        .done      (done),
        .dropped   (dropped)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic wait_en(output int n);
        n = 0;
        while (tx_enable !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (tx_enable !== 1'b1) n = -1;
    endtask

    task automatic measure_play(output int len, output int dones, output bit sel_moved);
        logic [2:0] sel0;
        sel0      = tx_sel;
        len       = 0;
        dones     = 0;
        sel_moved = 1'b0;
        while (tx_enable === 1'b1 && len < 200) begin
            len++;
            if (done === 1'b1) dones++;
            if (tx_sel !== sel0) sel_moved = 1'b1;
            tick();
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) n = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; stop = 1'b0; loop_en = 1'b0;
        repeat (3) @(posedge MCLK);
        #1;
        n_checks++;
        if ({tx_enable, tx_sel, busy, pending, done, dropped} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%0b sel=%0d busy=%0b pend=%h done=%0b drop=%0b, want all zero",
                     tx_enable, tx_sel, busy, pending, done, dropped);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_clip();
        int len, dones, gap;
        bit moved;
        req = 8'h04;
        tick();
        n_checks++;
        if (pending !== 8'h04 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_pending: pend=%h busy=%0b, want 04/0", pending, busy);
        end
        tick();
        n_checks++;
        if (busy !== 1'b1 || pending !== 8'h04 || tx_sel !== 3'd0) begin
            n_fail++; $display("FAIL single_arb: busy=%0b pend=%h sel=%0d, want 1/04/0", busy, pending, tx_sel);
        end
        tick();
        n_checks++;
        if (pending !== 8'h00 || tx_sel !== 3'd2 || tx_enable !== 1'b0) begin
            n_fail++; $display("FAIL single_setup1: pend=%h sel=%0d en=%0b, want 00/2/0", pending, tx_sel, tx_enable);
        end
        tick();
        n_checks++;
        if (tx_enable !== 1'b0) begin
            n_fail++; $display("FAIL single_setup2: en=%0b, want 0", tx_enable);
        end
        tick();
        n_checks++;
        if (tx_enable !== 1'b1) begin
            n_fail++; $display("FAIL single_play_start: en=%0b, want 1", tx_enable);
        end
        measure_play(len, dones, moved);
        n_checks++;
        if (len != 20 || dones != 1 || moved) begin
            n_fail++; $display("FAIL single_play_len: len=%0d dones=%0d moved=%0b, want 20/1/0", len, dones, moved);
        end
        gap = 0;
        while (busy === 1'b1 && gap < 50) begin
            gap++;
            tick();
        end
        n_checks++;
        if (gap != 4 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL single_gap: gap=%0d busy=%0b done=%0b, want 4/0/0", gap, busy, done);
        end
    endtask

    task automatic test_round_robin();
        int n, len, dones;
        bit moved;
        req = '0; tick();
        req = 8'h02; tick();
        wait_en(n);
        n_checks++;
        if (n < 0 || tx_sel !== 3'd1) begin
            n_fail++; $display("FAIL rr_first: wait=%0d sel=%0d, want clip 1", n, tx_sel);
        end
        req = 8'h0B; tick();
        n_checks++;
        if (pending !== 8'h09) begin
            n_fail++; $display("FAIL rr_pending: pend=%h, want 09", pending);
        end
        measure_play(len, dones, moved);
        n_checks++;
        if (len != 19 || moved) begin
            n_fail++; $display("FAIL rr_clip1: len=%0d moved=%0b, want 19/0", len, moved);
        end
        wait_en(n);
        n_checks++;
        if (n != 7 || tx_sel !== 3'd3) begin
            n_fail++; $display("FAIL rr_second: wait=%0d sel=%0d, want 7/3", n, tx_sel);
        end
        measure_play(len, dones, moved);
        n_checks++;
        if (len != 20 || dones != 1 || moved) begin
            n_fail++; $display("FAIL rr_clip3: len=%0d dones=%0d moved=%0b, want 20/1/0", len, dones, moved);
        end
        wait_en(n);
        n_checks++;
        if (n != 7 || tx_sel !== 3'd0) begin
            n_fail++; $display("FAIL rr_third: wait=%0d sel=%0d, want 7/0", n, tx_sel);
        end
        measure_play(len, dones, moved);
        wait_idle(n);
        n_checks++;
        if (len != 20 || moved || n < 0 || pending !== 8'h00) begin
            n_fail++; $display("FAIL rr_clip0: len=%0d moved=%0b idle_wait=%0d pend=%h, want 20/0/ok/00", len, moved, n, pending);
        end
    endtask

    task automatic test_dropped();
        int n;
        req = '0; tick();
        req = 8'h20; tick();
        n_checks++;
        if (dropped !== 1'b1 || pending !== 8'h00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL drop_unmasked: drop=%0b pend=%h busy=%0b, want 1/00/0", dropped, pending, busy);
        end
        tick();
        n_checks++;
        if (dropped !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL drop_pulse_end: drop=%0b busy=%0b, want 0/0", dropped, busy);
        end
        req = '0; tick();
        req = 8'h02; tick();
        wait_en(n);
        req = 8'h0A; tick();
        n_checks++;
        if (dropped !== 1'b0 || pending !== 8'h08) begin
            n_fail++; $display("FAIL drop_first_req3: drop=%0b pend=%h, want 0/08", dropped, pending);
        end
        req = 8'h02; tick();
        req = 8'h0A; tick();
        n_checks++;
        if (dropped !== 1'b1 || pending !== 8'h08) begin
            n_fail++; $display("FAIL drop_duplicate: drop=%0b pend=%h, want 1/08", dropped, pending);
        end
        tick();
        n_checks++;
        if (dropped !== 1'b0) begin
            n_fail++; $display("FAIL drop_dup_end: drop=%0b, want 0", dropped);
        end
        wait_idle(n);
        n_checks++;
        if (n < 0) begin
            n_fail++; $display("FAIL drop_idle_timeout: busy=%0b, want 0", busy);
        end
    endtask

    task automatic test_stop();
        int n, gap, done_seen, busy_seen;
        req = '0; tick();
        req = 8'h04; tick();
        wait_en(n);
        done_seen = 0;
        req = 8'h05; tick();
        n_checks++;
        if (pending !== 8'h01 || tx_enable !== 1'b1) begin
            n_fail++; $display("FAIL stop_pending: pend=%h en=%0b, want 01/1", pending, tx_enable);
        end
        repeat (8) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        stop = 1'b1;
        n_checks++;
        if (tx_enable !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL stop_cycle10: en=%0b done=%0b, want 1/0", tx_enable, done);
        end
        tick();
        stop = 1'b0;
        n_checks++;
        if (tx_enable !== 1'b0 || pending !== 8'h00 || done !== 1'b0 || busy !== 1'b1 || done_seen != 0) begin
            n_fail++; $display("FAIL stop_effect: en=%0b pend=%h done=%0b busy=%0b early_done=%0d, want 0/00/0/1/0",
                               tx_enable, pending, done, busy, done_seen);
        end
        gap = 0;
        while (busy === 1'b1 && gap < 50) begin
            if (done === 1'b1) done_seen++;
            gap++;
            tick();
        end
        n_checks++;
        if (gap != 4 || done_seen != 0) begin
            n_fail++; $display("FAIL stop_gap: gap=%0d dones=%0d, want 4/0", gap, done_seen);
        end
        busy_seen = 0;
        repeat (5) begin
            tick();
            if (busy !== 1'b0) busy_seen++;
        end
        stop = 1'b1; tick(); stop = 1'b0;
        if (busy !== 1'b0) busy_seen++;
        tick();
        n_checks++;
        if (busy_seen != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stop_stays_idle: busy_cycles=%0d, want 0", busy_seen);
        end
    endtask

    task automatic test_loop();
        int n, len, dones;
        bit moved;
        req = '0; tick();
        loop_en = 1'b1;
        req = 8'h01; tick();
        wait_en(n);
        n_checks++;
        if (n < 0 || tx_sel !== 3'd0) begin
            n_fail++; $display("FAIL loop_first: wait=%0d sel=%0d, want clip 0", n, tx_sel);
        end
        measure_play(len, dones, moved);
        wait_en(n);
        n_checks++;
        if (len != 20 || n != 6 || tx_sel !== 3'd0) begin
            n_fail++; $display("FAIL loop_replay: len=%0d wait=%0d sel=%0d, want 20/6/0", len, n, tx_sel);
        end
        req = 8'h03; tick();
        measure_play(len, dones, moved);
        wait_en(n);
        n_checks++;
        if (len != 19 || moved || n != 7 || tx_sel !== 3'd1) begin
            n_fail++; $display("FAIL loop_switch: len=%0d moved=%0b wait=%0d sel=%0d, want 19/0/7/1", len, moved, n, tx_sel);
        end
        loop_en = 1'b0;
        measure_play(len, dones, moved);
        wait_idle(n);
        n_checks++;
        if (len != 20 || dones != 1 || n != 4) begin
            n_fail++; $display("FAIL loop_exit: len=%0d dones=%0d idle_wait=%0d, want 20/1/4", len, dones, n);
        end
    endtask

    task automatic test_async_reset();
        int n, bad;
        req = '0; tick();
        req = 8'h04; tick();
        wait_en(n);
        req = 8'h05; tick();
        repeat (3) tick();
        rst_n = 1'b0;
        req   = '0;
        #1;
        n_checks++;
        if (tx_enable !== 1'b0 || tx_sel !== 3'd0 || pending !== 8'h00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: en=%0b sel=%0d pend=%h busy=%0b, want 0/0/00/0",
                               tx_enable, tx_sel, pending, busy);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            tick();
            if (busy !== 1'b0 || pending !== 8'h00) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL reset_release_idle: bad_cycles=%0d, want 0", bad);
        end
        req = 8'h04; tick();
        n_checks++;
        if (pending !== 8'h04) begin
            n_fail++; $display("FAIL reset_new_req: pend=%h, want 04", pending);
        end
        wait_idle(n);
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single_clip();
        test_round_robin();
        test_dropped();
        test_stop();
        test_loop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
